eca_engine: RTL and testbench

Parametrised elementary cellular-automaton engine, the generalised successor of the fixed Rule 110 core. It holds a WIDTH-cell row and accepts a row load as OUT_W-bit beats. On a start command it advances a programmable number of generations under any of the 256 Wolfram rules, with zero or wrap-around boundaries. It then streams the resulting row out in OUT_W-bit chunks over a valid/ready interface. It sits between the pin-level wrapper (switch inputs, 16-bit output bus) and the row storage, replacing the free-running single-rule datapath.

---
 rtl/eca_engine.sv | 164 ++++++++++++++++
 tb/tb_eca_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eca_engine.sv
// eca_engine: elementary cellular-automaton engine.
// Holds a WIDTH-cell row loaded as OUT_W-bit beats, advances it a programmable
// number of generations under any Wolfram rule, then streams it out in chunks.
// Optional feature macro: ECA_WRAP_EN (toroidal boundary selected by wrap_i).
// Without it the boundaries are always zero and wrap_i is ignored.

module eca_engine #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rule_i,
  input  logic             wrap_i,
  input  logic             load_valid_i,
  input  logic [OUT_W-1:0] load_data_i,
  output logic             load_ready_o,
  input  logic             start_i,
  input  logic [GEN_W-1:0] gens_i,
  output logic             busy_o,
  output logic             out_valid_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  output logic [GEN_W-1:0] gen_total_o
);

  localparam int unsigned NCH = WIDTH / OUT_W;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLast = KW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDump} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   cells_q;
  logic [GEN_W-1:0]   gen_total_q;
  logic [GEN_W-1:0]   rem_q;
  logic [7:0]         rule_q;
  logic [KW-1:0]      k_q;
  logic               busy_q;
  logic               out_valid_q;
  logic               out_last_q;

  logic               bnd_l;
  logic               bnd_r;
  logic [WIDTH+1:0]   ext;
  logic [WIDTH-1:0]   next_cells;
  logic [WIDTH-1:0]   load_shift;
  logic [WIDTH-1:0]   dump_shift;

`ifdef ECA_WRAP_EN
  logic wrap_q;

  // Boundary cells come from the opposite edge when the run was started in wrap mode.
  always_comb begin
    bnd_l = wrap_q ? cells_q[0] : 1'b0;
    bnd_r = wrap_q ? cells_q[WIDTH-1] : 1'b0;
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap_i;

  // Zero-padded boundaries only.
  always_comb begin
    bnd_l = 1'b0;
    bnd_r = 1'b0;
  end
`endif

  // One generation: each cell looks up rule bit {left, centre, right}.
  always_comb begin
    ext        = {bnd_l, cells_q, bnd_r};
    next_cells = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      next_cells[i] = rule_q[{ext[i+2], ext[i+1], ext[i]}];
    end
  end

  // Load shifts beats in at the LSB end; dump reads the chunk k from the MSB end.
  always_comb begin
    load_shift = (cells_q << OUT_W) | WIDTH'(load_data_i);
    dump_shift = cells_q << (32'(k_q) * OUT_W);
  end

  // Control FSM, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cells_q     <= '0;
      gen_total_q <= '0;
      rem_q       <= '0;
      rule_q      <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef ECA_WRAP_EN
      wrap_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            rule_q <= rule_i;
            rem_q  <= gens_i;
`ifdef ECA_WRAP_EN
            wrap_q <= wrap_i;
`endif
            busy_q <= 1'b1;
            if (gens_i == '0) begin
              state_q     <= StDump;
              out_valid_q <= 1'b1;
              out_last_q  <= (NCH == 1);
              k_q         <= '0;
            end else begin
              state_q <= StRun;
            end
          end else if (load_valid_i) begin
            cells_q     <= load_shift;
            gen_total_q <= '0;
          end
        end
        StRun: begin
          cells_q     <= next_cells;
          gen_total_q <= gen_total_q + 1'b1;
          rem_q       <= rem_q - 1'b1;
          if (rem_q == GEN_W'(1)) begin
            state_q     <= StDump;
            out_valid_q <= 1'b1;
            out_last_q  <= (NCH == 1);
            k_q         <= '0;
          end
        end
        StDump: begin
          if (out_ready_i) begin
            if (k_q == KLast) begin
              state_q     <= StIdle;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              k_q         <= '0;
            end else begin
              k_q        <= k_q + 1'b1;
              out_last_q <= ((k_q + 1'b1) == KLast);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // load_ready is the only combinational output; start wins over a load beat.
  always_comb begin
    load_ready_o = (state_q == StIdle) && !start_i;
    busy_o       = busy_q;
    out_valid_o  = out_valid_q;
    out_last_o   = out_last_q;
    out_data_o   = out_valid_q ? dump_shift[WIDTH-1 -: OUT_W] : '0;
    gen_total_o  = gen_total_q;
  end

endmodule

// File: tb/tb_eca_engine.sv
// Testbench for eca_engine (WIDTH=64, OUT_W=16): directed vectors with literal
// expectations plus a queue-based behavioural model compared every cycle.
module tb_eca_engine;

  localparam int W   = 64;
  localparam int OW  = 16;
  localparam int GW  = 16;
  localparam int NCH = W / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rule = 8'h00;
  logic          wrap = 1'b0;
  logic          load_valid = 1'b0;
  logic [OW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic [GW-1:0] gens = '0;
  logic          out_ready = 1'b0;
  logic          load_ready;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [GW-1:0] gen_total;

  int checks = 0;
  int errors = 0;

  eca_engine #(.WIDTH(W), .OUT_W(OW), .GEN_W(GW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rule_i      (rule),
    .wrap_i      (wrap),
    .load_valid_i(load_valid),
    .load_data_i (load_data),
    .load_ready_o(load_ready),
    .start_i     (start),
    .gens_i      (gens),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .gen_total_o (gen_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]  m_row = '0;
  logic [GW-1:0] m_gt = '0;
  int            m_left = 0;
  logic [OW-1:0] m_q[$];
  logic [7:0]    m_rule = 8'h00;
  logic          m_wrap = 1'b0;

  function automatic logic [W-1:0] eca_step(input logic [W-1:0] row, input logic [7:0] r,
                                            input logic wr);
    logic [W-1:0] nxt;
    logic l, c, rr;
    for (int i = 0; i < W; i++) begin
      c  = row[i];
      l  = (i == W - 1) ? (wr & row[0]) : row[(i + 1) % W];
      rr = (i == 0) ? (wr & row[W-1]) : row[(i + W - 1) % W];
      nxt[i] = r[{l, c, rr}];
    end
    return nxt;
  endfunction

  function automatic logic [W-1:0] eca_run(input logic [W-1:0] row, input logic [7:0] r,
                                           input logic wr, input int n);
    logic [W-1:0] x = row;
    for (int g = 0; g < n; g++) x = eca_step(x, r, wr);
    return x;
  endfunction

  task automatic m_push_row();
    for (int k = 0; k < NCH; k++) m_q.push_back(m_row[W-1-k*OW -: OW]);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_row = '0; m_gt = '0; m_left = 0; m_q.delete();
    end else if (m_left > 0) begin
      m_row = eca_step(m_row, m_rule, m_wrap);
      m_gt  = m_gt + 1'b1;
      m_left--;
      if (m_left == 0) m_push_row();
    end else if (m_q.size() > 0) begin
      if (out_ready) void'(m_q.pop_front());
    end else if (start) begin
      m_rule = rule;
`ifdef ECA_WRAP_EN
      m_wrap = wrap;
`else
      m_wrap = 1'b0;
`endif
      if (gens == '0) m_push_row();
      else m_left = int'(gens);
    end else if (load_valid) begin
      m_row = {m_row[W-OW-1:0], load_data};
      m_gt  = '0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic e_busy, e_valid;
    e_busy  = (m_left > 0) || (m_q.size() > 0);
    e_valid = (m_left == 0) && (m_q.size() > 0);
    check("busy", busy, e_busy);
    check("out_valid", out_valid, e_valid);
    check("out_data", out_data, e_valid ? m_q[0] : '0);
    check("out_last", out_last, e_valid && (m_q.size() == 1));
    check("gen_total", gen_total, m_gt);
    check("load_ready", load_ready, !e_busy && !start);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_row(input logic [W-1:0] row);
    for (int k = 0; k < NCH; k++) begin
      load_valid = 1'b1;
      load_data  = row[W-1-k*OW -: OW];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic collect(output logic [W-1:0] res, output int n);
    bit done = 0;
    res = '0;
    n   = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (out_valid) begin
        res = {res[W-OW-1:0], out_data};
        n++;
        if (out_last) done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout got no_last expected out_last");
    end
    tick();
  endtask

  task automatic run(input logic [7:0] r, input logic w, input logic [GW-1:0] g,
                     output logic [W-1:0] res);
    int n;
    rule = r; wrap = w; gens = g; start = 1'b1;
    tick();
    start = 1'b0;
    collect(res, n);
    check("chunk_count", 64'(n), 64'(NCH));
  endtask

  logic [W-1:0] res;
  int n;

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Rule 110, single seed, three generations.
    load_row(64'h0000_0000_0000_0001);
    run(8'h6E, 1'b0, 16'd3, res);
    check("r110_g3", res, 64'h0000_0000_0000_000D);
    check("gen_total_3", gen_total, 64'd3);

    // MSB seed against the boundary.
    load_row(64'h8000_0000_0000_0000);
    run(8'h6E, 1'b0, 16'd1, res);
    check("r110_nowrap", res, 64'h8000_0000_0000_0000);
    load_row(64'h8000_0000_0000_0000);
    run(8'h6E, 1'b1, 16'd1, res);
`ifdef ECA_WRAP_EN
    check("r110_wrap", res, 64'h8000_0000_0000_0001);
`else
    check("r110_wrap_ignored", res, 64'h8000_0000_0000_0000);
`endif

    // Rule 90, then continue from the retained row.
    load_row(64'h0000_0000_0000_0100);
    run(8'h5A, 1'b0, 16'd1, res);
    check("r90_g1", res, 64'h0000_0000_0000_0280);
    run(8'h5A, 1'b0, 16'd1, res);
    check("r90_cont", res, 64'h0000_0000_0000_0440);
    check("gen_total_cont", gen_total, 64'd2);

    // Four-beat load, zero generations, output stalled for a while.
    load_row(64'h1111_2222_3333_4444);
    rule = 8'h00; gens = '0; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_data", out_data, 64'h1111);
      check("stall_valid", out_valid, 64'd1);
      check("stall_last", out_last, 64'd0);
    end
    @(posedge clk);
    #2;
    collect(res, n);
    check("passthru", res, 64'h1111_2222_3333_4444);
    check("passthru_chunks", 64'(n), 64'd4);

    // start and load_valid together: the beat is refused.
    load_valid = 1'b1; load_data = 16'hFFFF; start = 1'b1; gens = '0;
    @(negedge clk);
    check("ld_rdy_with_start", load_ready, 64'd0);
    @(posedge clk);
    #2;
    load_valid = 1'b0; start = 1'b0;
    collect(res, n);
    check("row_unchanged", res, 64'h1111_2222_3333_4444);

    // A few more rules checked against the model's multi-step result.
    load_row(64'h0123_4567_89AB_CDEF);
    run(8'd30, 1'b1, 16'd5, res);
`ifdef ECA_WRAP_EN
    check("r30_g5", res, eca_run(64'h0123_4567_89AB_CDEF, 8'd30, 1'b1, 5));
`else
    check("r30_g5", res, eca_run(64'h0123_4567_89AB_CDEF, 8'd30, 1'b0, 5));
`endif
    run(8'd184, 1'b0, 16'd7, res);
    check("r184_g7", res,
          eca_run(eca_run(64'h0123_4567_89AB_CDEF, 8'd30,
`ifdef ECA_WRAP_EN
                          1'b1,
`else
                          1'b0,
`endif
                          5), 8'd184, 1'b0, 7));

    // Reset in the middle of a long run.
    load_row(64'h0000_0000_0000_0001);
    rule = 8'h6E; wrap = 1'b0; gens = 16'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 64'd0);
    check("rst_valid", out_valid, 64'd0);
    check("rst_gen_total", gen_total, 64'd0);
    @(posedge clk);
    #2;
    run(8'h6E, 1'b0, 16'd0, res);
    check("rst_row_zero", res, 64'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
